// File: rtl/filter_base_addr_gen.sv
// Filter base address generator: walks the scratchpad base address of each
// filter in a multi-filter weight buffer, with single-pass or circular modes.
module filter_base_addr_gen #(
  parameter int ADDR_W     = 8,
  parameter int IDX_W      = 4,
  parameter int SPAD_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              start,
  input  logic              inc,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_filter_size,
  input  logic [IDX_W-1:0]  cfg_num_filters,
  input  logic              cfg_circular,
  output logic [ADDR_W-1:0] base_addr,
  output logic [IDX_W-1:0]  filter_idx,
  output logic              busy,
  output logic              cout,
  output logic              done,
  output logic              cfg_err
);

  localparam int EW = ADDR_W + IDX_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q, size_q;
  logic [IDX_W-1:0]  num_q;
  logic              circ_q;

  // End of the last filter, wide enough that the product cannot overflow.
  logic [EW-1:0] cfg_end;
  logic          cfg_ok;
  logic          last;

  assign cfg_end = EW'(cfg_base) + EW'(cfg_filter_size) * EW'(cfg_num_filters);
  assign cfg_ok  = (cfg_num_filters != '0) && (cfg_filter_size != '0) &&
                   (cfg_end <= EW'(SPAD_DEPTH));
  assign last    = (filter_idx == num_q - IDX_W'(1));

  always_ff @(posedge clk) begin
    if (rst || init) begin
      state      <= IDLE;
      base_q     <= '0;
      size_q     <= '0;
      num_q      <= '0;
      circ_q     <= 1'b0;
      base_addr  <= '0;
      filter_idx <= '0;
      busy       <= 1'b0;
      cout       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cout <= 1'b0;
      done <= 1'b0;
      if (start) begin
        filter_idx <= '0;
        if (cfg_ok) begin
          base_q    <= cfg_base;
          size_q    <= cfg_filter_size;
          num_q     <= cfg_num_filters;
          circ_q    <= cfg_circular;
          base_addr <= cfg_base;
          state     <= RUN;
          busy      <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          base_addr <= '0;
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_err   <= 1'b1;
        end
      end else if (inc && state == RUN) begin
        if (last) begin
          cout       <= 1'b1;
          base_addr  <= base_q;
          filter_idx <= '0;
          if (!circ_q) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          // Incremental stride add; legal configs keep this below SPAD_DEPTH.
          base_addr  <= base_addr + size_q;
          filter_idx <= filter_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_base_addr_gen.sv
// Scoreboarded random/directed bench for filter_base_addr_gen against an
// arithmetic reference model (address = base + size * index).
module tb_filter_base_addr_gen;

  logic       clk = 1'b0;
  logic       rst, init, start, inc, cfg_circular;
  logic [7:0] cfg_base, cfg_filter_size;
  logic [3:0] cfg_num_filters;
  logic [7:0] base_addr;
  logic [3:0] filter_idx;
  logic       busy, cout, done, cfg_err;

  filter_base_addr_gen #(.ADDR_W(8), .IDX_W(4), .SPAD_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .inc(inc),
    .cfg_base(cfg_base), .cfg_filter_size(cfg_filter_size),
    .cfg_num_filters(cfg_num_filters), .cfg_circular(cfg_circular),
    .base_addr(base_addr), .filter_idx(filter_idx), .busy(busy),
    .cout(cout), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, idx, busy, cout, done, err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pass is "running" or "finished"; address follows index.
  bit m_running, m_finished, m_circ, m_err;
  int m_base, m_size, m_num, m_k;

  function automatic void chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input bit r, input bit i, input bit s, input bit n,
                       input int b, input int sz, input int nf, input bit c);
    exp_t e;
    bit   ev_cout, ev_done;
    int   cend;
    @(negedge clk);
    rst = r; init = i; start = s; inc = n;
    if (s) begin
      cfg_base = 8'(b); cfg_filter_size = 8'(sz);
      cfg_num_filters = 4'(nf); cfg_circular = c;
    end else begin
      cfg_base = 8'($urandom); cfg_filter_size = 8'($urandom);
      cfg_num_filters = 4'($urandom); cfg_circular = 1'($urandom);
    end
    ev_cout = 0; ev_done = 0;
    if (r || i) begin
      m_running = 0; m_finished = 0; m_err = 0; m_k = 0;
    end else if (s) begin
      cend = b + sz * nf;
      m_k = 0;
      if (nf == 0 || sz == 0 || cend > 256) begin
        m_err = 1; m_running = 0; m_finished = 0;
      end else begin
        m_err = 0; m_running = 1; m_finished = 0;
        m_base = b; m_size = sz; m_num = nf; m_circ = c;
      end
    end else if (n && m_running) begin
      if (m_k == m_num - 1) begin
        m_k = 0; ev_cout = 1;
        if (!m_circ) begin m_running = 0; m_finished = 1; ev_done = 1; end
      end else m_k++;
    end
    e.a    = (m_running || m_finished) ? m_base + m_size * m_k : 0;
    e.idx  = m_k;
    e.busy = m_running;
    e.cout = ev_cout;
    e.done = ev_done;
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic go(input int b, input int sz, input int nf, input bit c);
    drive(0, 0, 1, 0, b, sz, nf, c);
  endtask

  task automatic incs(input int cnt);
    for (int k = 0; k < cnt; k++) drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("base_addr", 32'(base_addr), e.a);
        chk("filter_idx", 32'(filter_idx), e.idx);
        chk("busy", 32'(busy), e.busy);
        chk("cout", 32'(cout), e.cout);
        chk("done", 32'(done), e.done);
        chk("cfg_err", 32'(cfg_err), e.err);
      end
    end
  end

  initial begin
    rst = 1; init = 0; start = 0; inc = 0;
    cfg_base = 0; cfg_filter_size = 0; cfg_num_filters = 0; cfg_circular = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    // basic single pass, then an extra inc in DONE
    go(0, 16, 4, 0); incs(5); drive(0, 0, 0, 0, 0, 0, 0, 0);
    // circular with offset
    go(8, 10, 3, 1); incs(7);
    // range error, ignored incs, then legal start
    go(200, 20, 3, 0); incs(2); go(0, 20, 3, 0); incs(1);
    // degenerate configs and num=1
    go(0, 16, 0, 0); incs(1); go(0, 0, 3, 0); incs(1);
    go(30, 5, 1, 1); incs(3); go(30, 5, 1, 0); incs(2);
    // exact-fit boundary and one past it
    go(0, 64, 4, 0); incs(4); go(1, 64, 4, 0);
    // priority: start+inc mid-pass, init+inc, rst clears cfg_err
    go(0, 16, 4, 0); incs(2);
    drive(0, 0, 1, 1, 4, 16, 4, 0); incs(1);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    go(250, 10, 2, 0);
    drive(1, 0, 1, 1, 0, 16, 4, 0);
    go(250, 10, 2, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bit s;
      s = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0, s,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(0, 40),
            $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 40),
            $urandom_range(0, 15), 1'($urandom));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
